elevator_call_scheduler: RTL and testbench

Request side of the elevator controller: latches hall/car call buttons for every floor, keeps a pending-call set, and issues one target floor at a time to the elevator state machine using a SCAN (keep-direction) policy. It watches the state machine's current floor and idle flag to detect arrival, clears the served call, holds a door-dwell interval, then issues the next target. Sits between the button inputs (`ui_in`) and the `requested_floor` input of the elevator state machine, replacing the one-hot-to-value decoder.

---
 rtl/elevator_call_scheduler.sv | 169 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator call scheduler: latches floor calls, issues one target floor at a time,
// clears the call on arrival and holds a door-dwell interval before the next target.
module elevator_call_scheduler #(
  parameter int N_FLOORS     = 9,
  parameter int DWELL_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [3:0]          current_floor,
  input  logic                elevator_idle,
  output logic [3:0]          target_floor,
  output logic                target_valid,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, DWELL = 2'd2} state_t;

  state_t              state_r, state_nxt;
  logic [N_FLOORS-1:0] pending_r, pending_nxt, clear_s, cur_mask_s, tgt_mask_s;
  logic [3:0]          target_r, target_nxt, up_floor_s, dn_floor_s, cand_floor_s;
  logic                valid_r, valid_nxt, dir_up_r, dir_nxt, door_r, door_nxt;
  logic [CW-1:0]       cnt_r, cnt_nxt;
  logic                up_found_s, dn_found_s, here_s, cand_found_s, cand_dir_s;

  assign target_floor = target_r;
  assign target_valid = valid_r;
  assign dir_up       = dir_up_r;
  assign pending      = pending_r;
  assign door_open    = door_r;

  // Candidate search: nearest pending floor above and below the current floor.
  always_comb begin
    up_found_s = 1'b0;
    up_floor_s = 4'd0;
    dn_found_s = 1'b0;
    dn_floor_s = 4'd0;
    here_s     = 1'b0;
    cur_mask_s = '0;
    tgt_mask_s = '0;
    for (int f = N_FLOORS - 1; f >= 0; f--) begin
      if (pending_r[f] && (4'(f) > current_floor)) begin
        up_found_s = 1'b1;
        up_floor_s = 4'(f);
      end else begin
      end
    end
    for (int f = 0; f < N_FLOORS; f++) begin
      if (pending_r[f] && (4'(f) < current_floor)) begin
        dn_found_s = 1'b1;
        dn_floor_s = 4'(f);
      end else begin
      end
      cur_mask_s[f] = (4'(f) == current_floor);
      tgt_mask_s[f] = (4'(f) == target_r);
      if (pending_r[f] && (4'(f) == current_floor)) begin
        here_s = 1'b1;
      end else begin
      end
    end
    // Keep direction while calls lie ahead, otherwise reverse.
    if (dir_up_r) begin
      cand_found_s = up_found_s || dn_found_s;
      cand_floor_s = up_found_s ? up_floor_s : dn_floor_s;
      cand_dir_s   = up_found_s ? 1'b1 : ~dn_found_s;
    end else begin
      cand_found_s = up_found_s || dn_found_s;
      cand_floor_s = dn_found_s ? dn_floor_s : up_floor_s;
      cand_dir_s   = dn_found_s ? 1'b0 : up_found_s;
    end
  end

  // Next-state and output logic of the scheduling FSM.
  always_comb begin
    state_nxt  = state_r;
    target_nxt = target_r;
    valid_nxt  = valid_r;
    dir_nxt    = dir_up_r;
    door_nxt   = door_r;
    cnt_nxt    = cnt_r;
    clear_s    = '0;
    case (state_r)
      IDLE: begin
        target_nxt = current_floor;
        valid_nxt  = 1'b0;
        door_nxt   = 1'b0;
        if (here_s) begin
          clear_s   = cur_mask_s;
          state_nxt = DWELL;
          door_nxt  = 1'b1;
          cnt_nxt   = CW'(DWELL_CYCLES - 1);
        end else if (cand_found_s) begin
          target_nxt = cand_floor_s;
          dir_nxt    = cand_dir_s;
          valid_nxt  = 1'b1;
          state_nxt  = SERVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SERVE: begin
        valid_nxt = 1'b1;
        if ((current_floor == target_r) && elevator_idle) begin
          clear_s    = tgt_mask_s;
          state_nxt  = DWELL;
          door_nxt   = 1'b1;
          cnt_nxt    = CW'(DWELL_CYCLES - 1);
          target_nxt = current_floor;
          valid_nxt  = 1'b0;
        end else if (dir_up_r && up_found_s && (up_floor_s < target_r)) begin
          target_nxt = up_floor_s;
        end else if (!dir_up_r && dn_found_s && (dn_floor_s > target_r)) begin
          target_nxt = dn_floor_s;
        end else begin
          target_nxt = target_r;
        end
      end
      DWELL: begin
        // target_r tracks last cycle's floor, so a mismatch means the car moved with the door open.
        target_nxt = current_floor;
        valid_nxt  = 1'b0;
        clear_s    = cur_mask_s;
        if (current_floor != target_r) begin
          state_nxt = IDLE;
          door_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt_r == '0) begin
          state_nxt = IDLE;
          door_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        door_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
    pending_nxt = (pending_r | call_btn) & ~clear_s;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= '0;
      target_r  <= 4'd0;
      valid_r   <= 1'b0;
      dir_up_r  <= 1'b1;
      door_r    <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_nxt;
      pending_r <= pending_nxt;
      target_r  <= target_nxt;
      valid_r   <= valid_nxt;
      dir_up_r  <= dir_nxt;
      door_r    <= door_nxt;
      cnt_r     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed testbench for elevator_call_scheduler: one task per scenario with inline checks.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] call_btn = 9'd0;
  logic [3:0] current_floor = 4'd0;
  logic       elevator_idle = 1'b1;
  logic [3:0] target_floor;
  logic       target_valid;
  logic       dir_up;
  logic [8:0] pending;
  logic       door_open;
  int         total = 0;
  int         bad = 0;

  elevator_call_scheduler #(.N_FLOORS(9), .DWELL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .call_btn(call_btn), .current_floor(current_floor),
    .elevator_idle(elevator_idle), .target_floor(target_floor), .target_valid(target_valid),
    .dir_up(dir_up), .pending(pending), .door_open(door_open)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts door_open cycles starting from the current (already open) cycle, bounded.
  task automatic run_dwell(output int n);
    n = 0;
    while (door_open === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; call_btn = 9'h1FF; current_floor = 4'd0;
    tick(); tick();
    total++; if (pending !== 9'd0) begin bad++; $display("FAIL rst_pending got=%h exp=0", pending); end
    total++; if ({target_valid, door_open, dir_up} !== 3'b001) begin bad++; $display("FAIL rst_flags got=%b exp=001", {target_valid, door_open, dir_up}); end
    total++; if (target_floor !== 4'd0) begin bad++; $display("FAIL rst_target got=%0d exp=0", target_floor); end
    call_btn = 9'd0; rst = 1'b0;
    tick();
    total++; if (pending !== 9'd0 || target_valid !== 1'b0) begin bad++; $display("FAIL rst_release got=%h/%b exp=0/0", pending, target_valid); end
  endtask

  task automatic test_single_call();
    int n;
    call_btn = 9'b000100000; tick();
    total++; if (pending !== 9'b000100000 || target_valid !== 1'b0) begin bad++; $display("FAIL single_latch got=%h/%b exp=020/0", pending, target_valid); end
    call_btn = 9'd0; tick();
    total++; if (target_valid !== 1'b1 || target_floor !== 4'd5 || dir_up !== 1'b1) begin bad++; $display("FAIL single_issue got=%b/%0d/%b exp=1/5/1", target_valid, target_floor, dir_up); end
    current_floor = 4'd3; elevator_idle = 1'b0; tick();
    total++; if (target_floor !== 4'd5 || target_valid !== 1'b1) begin bad++; $display("FAIL single_hold got=%0d/%b exp=5/1", target_floor, target_valid); end
    current_floor = 4'd5; elevator_idle = 1'b1; tick();
    total++; if (door_open !== 1'b1 || pending !== 9'd0 || target_valid !== 1'b0) begin bad++; $display("FAIL single_arrive got=%b/%h/%b exp=1/0/0", door_open, pending, target_valid); end
    run_dwell(n);
    total++; if (n !== 16) begin bad++; $display("FAIL single_dwell_len got=%0d exp=16", n); end
    total++; if (target_floor !== 4'd5 || target_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%0d/%b exp=5/0", target_floor, target_valid); end
  endtask

  task automatic test_scan_order();
    int n;
    current_floor = 4'd4; tick();
    call_btn = 9'b101000100; tick();
    call_btn = 9'd0; tick();
    total++; if (target_floor !== 4'd6 || target_valid !== 1'b1 || dir_up !== 1'b1) begin bad++; $display("FAIL scan_first got=%0d/%b/%b exp=6/1/1", target_floor, target_valid, dir_up); end
    current_floor = 4'd6; tick();
    run_dwell(n);
    tick();
    total++; if (target_floor !== 4'd8 || target_valid !== 1'b1 || dir_up !== 1'b1) begin bad++; $display("FAIL scan_second got=%0d/%b/%b exp=8/1/1", target_floor, target_valid, dir_up); end
    current_floor = 4'd8; tick();
    run_dwell(n);
    tick();
    total++; if (target_floor !== 4'd2 || target_valid !== 1'b1 || dir_up !== 1'b0) begin bad++; $display("FAIL scan_reverse got=%0d/%b/%b exp=2/1/0", target_floor, target_valid, dir_up); end
    current_floor = 4'd2; tick();
    run_dwell(n);
    total++; if (pending !== 9'd0 || door_open !== 1'b0) begin bad++; $display("FAIL scan_done got=%h/%b exp=0/0", pending, door_open); end
  endtask

  task automatic test_on_the_way();
    int n;
    current_floor = 4'd0; tick();
    call_btn = 9'b010000000; tick();
    call_btn = 9'd0; tick();
    total++; if (target_floor !== 4'd7 || dir_up !== 1'b1) begin bad++; $display("FAIL otw_issue got=%0d/%b exp=7/1", target_floor, dir_up); end
    current_floor = 4'd1; elevator_idle = 1'b0; call_btn = 9'b000001000; tick();
    total++; if (target_floor !== 4'd7) begin bad++; $display("FAIL otw_before got=%0d exp=7", target_floor); end
    call_btn = 9'd0; tick();
    total++; if (target_floor !== 4'd3 || target_valid !== 1'b1) begin bad++; $display("FAIL otw_retarget got=%0d/%b exp=3/1", target_floor, target_valid); end
    current_floor = 4'd3; elevator_idle = 1'b1; tick();
    total++; if (pending !== 9'b010000000 || door_open !== 1'b1) begin bad++; $display("FAIL otw_arrive got=%h/%b exp=080/1", pending, door_open); end
    run_dwell(n);
    tick();
    total++; if (target_floor !== 4'd7 || target_valid !== 1'b1) begin bad++; $display("FAIL otw_resume got=%0d/%b exp=7/1", target_floor, target_valid); end
    current_floor = 4'd7; tick();
    run_dwell(n);
  endtask

  task automatic test_same_floor();
    current_floor = 4'd2; tick();
    call_btn = 9'b000000100; tick();
    total++; if (pending !== 9'b000000100 || door_open !== 1'b0) begin bad++; $display("FAIL same_latch got=%h/%b exp=004/0", pending, door_open); end
    tick();
    total++; if (door_open !== 1'b1 || target_valid !== 1'b0 || pending !== 9'd0) begin bad++; $display("FAIL same_dwell got=%b/%b/%h exp=1/0/0", door_open, target_valid, pending); end
    for (int i = 0; i < 15; i++) tick();
    total++; if (door_open !== 1'b1 || pending !== 9'd0) begin bad++; $display("FAIL same_held got=%b/%h exp=1/0", door_open, pending); end
    call_btn = 9'd0; tick();
    total++; if (door_open !== 1'b0 || pending !== 9'd0 || target_valid !== 1'b0) begin bad++; $display("FAIL same_end got=%b/%h/%b exp=0/0/0", door_open, pending, target_valid); end
  endtask

  task automatic test_mid_reset();
    current_floor = 4'd8; tick();
    call_btn = 9'b001000000; tick();
    call_btn = 9'd0; tick();
    total++; if (target_floor !== 4'd6 || target_valid !== 1'b1 || dir_up !== 1'b0) begin bad++; $display("FAIL mrst_issue got=%0d/%b/%b exp=6/1/0", target_floor, target_valid, dir_up); end
    rst = 1'b1; call_btn = 9'b000000010; tick();
    total++; if (target_valid !== 1'b0 || pending !== 9'd0 || dir_up !== 1'b1 || target_floor !== 4'd0) begin bad++; $display("FAIL mrst_state got=%b/%h/%b/%0d exp=0/0/1/0", target_valid, pending, dir_up, target_floor); end
    rst = 1'b0; call_btn = 9'd0; tick();
    total++; if (pending !== 9'd0 || target_valid !== 1'b0) begin bad++; $display("FAIL mrst_after got=%h/%b exp=0/0", pending, target_valid); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_on_the_way();
    test_same_floor();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
